// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The master side drives operands and accepts results; the slave side is the adder.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;

  modport master (
    output in_valid, a, b, carryin, sub, out_ready,
    input  in_ready, out_valid, sum, carryout, overflow
  );

  modport slave (
    input  in_valid, a, b, carryin, sub, out_ready,
    output in_ready, out_valid, sum, carryout, overflow
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Add/subtract with the carry chain split into STAGES equal slices, one slice per
// pipeline stage, with valid/ready flow control and bubble compression.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic              clk,
  input logic              reset_n,
  pipelined_addsub_if.slave bus
);

  localparam int unsigned SLICE    = WIDTH / STAGES;
  localparam int unsigned SLICE_W1 = SLICE + 1;
  localparam int unsigned LAST     = STAGES - 1;
  localparam int unsigned OPS      = (STAGES > 1) ? STAGES - 1 : 1;

  if ((STAGES < 1) || (WIDTH < 2) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES >= 1");
  end

  // Stage state: partial sum, slice carry, valid, and operands still to be consumed
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_q [OPS];
  logic [WIDTH-1:0]  b_q [OPS];
  logic              ovf_q;

  // Per-stage inputs (from the bus for stage 0, from the previous stage otherwise)
  logic [STAGES-1:0]   load;
  logic [STAGES-1:0]   v_in;
  logic [STAGES-1:0]   c_in;
  logic [WIDTH-1:0]    a_in  [STAGES];
  logic [WIDTH-1:0]    b_in  [STAGES];
  logic [WIDTH-1:0]    s_in  [STAGES];
  logic [WIDTH-1:0]    s_nxt [STAGES];
  logic [SLICE_W1-1:0] part  [STAGES];
  logic                ovf_nxt;

  // Load chain: a stage takes data when empty or when its successor takes its data
  always_comb begin
    load       = '0;
    load[LAST] = ~vld[LAST] | bus.out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      load[k] = ~vld[k] | load[k+1];
    end
  end

  // Slice adders; subtraction inverts B and forces the initial carry to 1
  always_comb begin
    v_in    = '0;
    c_in    = '0;
    v_in[0] = bus.in_valid;
    c_in[0] = bus.sub | bus.carryin;
    a_in[0] = bus.a;
    b_in[0] = bus.sub ? ~bus.b : bus.b;
    s_in[0] = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      v_in[k] = vld[k-1];
      c_in[k] = c_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
    end
    for (int k = 0; k < int'(STAGES); k++) begin
      part[k]  = SLICE_W1'(a_in[k][k*SLICE +: SLICE]) + SLICE_W1'(b_in[k][k*SLICE +: SLICE])
               + SLICE_W1'(c_in[k]);
      s_nxt[k] = s_in[k];
      s_nxt[k][k*SLICE +: SLICE] = part[k][SLICE-1:0];
    end
    // Carry into the MSB recovered from the MSB sum bit and its operand bits
    ovf_nxt = s_nxt[LAST][WIDTH-1] ^ a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1]
            ^ part[LAST][SLICE];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        s_q[k] <= '0;
      end
      for (int k = 0; k < int'(OPS); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (load[k]) begin
          vld[k] <= v_in[k];
          if (v_in[k]) begin
            s_q[k] <= s_nxt[k];
            c_q[k] <= part[k][SLICE];
          end
        end
      end
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
        if (load[k] && v_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
        end
      end
      if (load[LAST] && v_in[LAST]) begin
        ovf_q <= ovf_nxt;
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = vld[LAST];
  assign bus.sum       = s_q[LAST];
  assign bus.carryout  = c_q[LAST];
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: a 32-bit/4-stage and a 4-bit/2-stage instance.
module tb_pipelined_addsub;

  localparam int S32 = 4;
  localparam int S4  = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(32)) b32 ();
  pipelined_addsub_if #(.WIDTH(4))  b4 ();

  pipelined_addsub #(.WIDTH(32), .STAGES(S32)) u32 (.clk(clk), .reset_n(reset_n), .bus(b32));
  pipelined_addsub #(.WIDTH(4),  .STAGES(S4))  u4  (.clk(clk), .reset_n(reset_n), .bus(b4));

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        o;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q4[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stalls = 0;
  bit   chk_lat = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: wide add, overflow from operand/result sign agreement
  function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sb);
    exp_t        e;
    logic [32:0] ext;
    logic [31:0] bx;
    bx    = sb ? ~b : b;
    ext   = {1'b0, a} + {1'b0, bx} + 33'(sb | cin);
    e.sum = ext[31:0];
    e.c   = ext[32];
    e.o   = (a[31] == bx[31]) && (ext[31] != a[31]);
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // 32-bit result monitor, including output stability while stalled
  logic [33:0] held32;
  bit          hold32 = 1'b0;
  always @(negedge clk) begin : mon32
    exp_t e;
    if (!reset_n) begin
      hold32 = 1'b0;
    end else begin
      if (hold32) check("stall_stable32", {b32.sum, b32.carryout, b32.overflow}, held32);
      hold32 = b32.out_valid && !b32.out_ready;
      held32 = {b32.sum, b32.carryout, b32.overflow};
      if (b32.out_valid && b32.out_ready) begin
        if (q32.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out32: got sum %0h with no result expected", b32.sum);
        end else begin
          e = q32.pop_front();
          check("result32", {b32.sum, b32.carryout, b32.overflow}, {e.sum, e.c, e.o});
          if (e.lat) check("latency32", 64'(cyc - e.acc), 64'(S32));
        end
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (reset_n && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out4: got sum %0h with no result expected", b4.sum);
      end else begin
        e = q4.pop_front();
        check("result4", {b4.sum, b4.carryout, b4.overflow}, {e.sum[3:0], e.c, e.o});
        if (e.lat) check("latency4", 64'(cyc - e.acc), 64'(S4));
      end
    end
  end

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sb, input logic [31:0] es, input logic ec, input logic eo);
    int n = 0;
    bit ok = 1'b0;
    b32.a = a; b32.b = b; b32.carryin = cin; b32.sub = sb; b32.in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (b32.in_ready) begin
        q32.push_back('{es, ec, eo, cyc, chk_lat});
        ok = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      n++;
    end
    b32.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept32: got no in_ready within 50 cycles required 1");
    end
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic sb, input logic [3:0] es, input logic ec, input logic eo);
    int n = 0;
    bit ok = 1'b0;
    b4.a = a; b4.b = b; b4.carryin = cin; b4.sub = sb; b4.in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (b4.in_ready) begin
        q4.push_back('{32'(es), ec, eo, cyc, chk_lat});
        ok = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    b4.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept4: got no in_ready within 50 cycles required 1");
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q4.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q32.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d results pending required 0/0", q32.size(), q4.size());
    end
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t        e;
    logic [31:0] sa [10];
    logic [31:0] sbv[10];
    logic        sc [10];
    logic        ss [10];
    int          idx;

    b32.in_valid = 0; b32.a = '0; b32.b = '0; b32.carryin = 0; b32.sub = 0; b32.out_ready = 1;
    b4.in_valid  = 0; b4.a  = '0; b4.b  = '0; b4.carryin  = 0; b4.sub  = 0; b4.out_ready  = 1;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid32", 64'(b32.out_valid), 0);
    check("rst_in_ready32", 64'(b32.in_ready), 1);
    check("rst_outputs32", {b32.sum, b32.carryout, b32.overflow}, 0);
    check("rst_out_valid4", 64'(b4.out_valid), 0);
    check("rst_in_ready4", 64'(b4.in_ready), 1);
    check("rst_outputs4", {b4.sum, b4.carryout, b4.overflow}, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    #1 check("in_ready_after_rst32", 64'(b32.in_ready), 1);
    @(posedge clk); #1;

    // 4-bit, 2-stage directed vectors: a, b, cin, sub -> sum, carryout, overflow
    send4(4'b1111, 4'b0001, 0, 0, 4'b0000, 1, 0);
    send4(4'b1000, 4'b1111, 0, 0, 4'b0111, 1, 1);
    send4(4'b1000, 4'b0001, 0, 1, 4'b0111, 1, 1);
    send4(4'b0000, 4'b0001, 0, 1, 4'b1111, 0, 0);
    send4(4'b0111, 4'b0001, 0, 0, 4'b1000, 0, 1);
    send4(4'b0101, 4'b0011, 1, 1, 4'b0010, 1, 0);

    // 32-bit, 4-stage directed vectors, including full-width carry ripple
    send32(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1);
    send32(32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 32'h0000_0000, 1, 0);
    send32(32'h1234_5678, 32'h1111_1111, 0, 0, 32'h2345_6789, 0, 0);
    send32(32'h8000_0000, 32'h0000_0001, 0, 1, 32'h7FFF_FFFF, 1, 1);
    send32(32'h0000_0005, 32'h0000_0005, 1, 1, 32'h0000_0000, 1, 0);
    send32(32'h0000_FFFF, 32'h0000_0001, 0, 0, 32'h0001_0000, 0, 0);
    drain();

    // Back-to-back stream of 16 with out_ready held high
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      logic        rc, rs;
      ra = $urandom(); rb = $urandom();
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      e = model32(ra, rb, rc, rs);
      send32(ra, rb, rc, rs, e.sum, e.c, e.o);
    end
    drain();
    check("stream_stalls", 64'(stalls), 0);

    // Output stall with continuous input: exactly STAGES accepted, then drain in order
    chk_lat = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sa[i] = $urandom(); sbv[i] = $urandom();
      sc[i] = 1'($urandom_range(0, 1)); ss[i] = 1'($urandom_range(0, 1));
    end
    b32.out_ready = 1'b0;
    idx = 0;
    b32.a = sa[0]; b32.b = sbv[0]; b32.carryin = sc[0]; b32.sub = ss[0]; b32.in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (b32.in_ready) begin
        e = model32(sa[idx], sbv[idx], sc[idx], ss[idx]);
        q32.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
      b32.a = sa[idx]; b32.b = sbv[idx]; b32.carryin = sc[idx]; b32.sub = ss[idx];
    end
    check("stall_accepts", 64'(idx), 64'(S32));
    @(negedge clk);
    check("stall_in_ready", 64'(b32.in_ready), 0);
    @(posedge clk); #1;
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    drain();

    // Reset with three results in flight: all discarded immediately
    b32.out_ready = 1'b0;
    send32(32'h0000_0001, 32'h0000_0002, 0, 0, 32'h0000_0003, 0, 0);
    send32(32'h0000_0010, 32'h0000_0020, 0, 0, 32'h0000_0030, 0, 0);
    send32(32'h0000_0100, 32'h0000_0200, 0, 0, 32'h0000_0300, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(b32.out_valid), 0);
    check("midrst_outputs", {b32.sum, b32.carryout, b32.overflow}, 0);
    check("midrst_in_ready", 64'(b32.in_ready), 1);
    q32.delete();
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1 check("in_ready_after_midrst", 64'(b32.in_ready), 1);
    @(posedge clk); #1;
    b32.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_lat = 1'b1;
    send32(32'hDEAD_BEEF, 32'h0000_0001, 0, 1, 32'hDEAD_BEEE, 1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
